// File: rtl/msg_schedule_if.sv
// Block-in / schedule-out bundle shared by the feeder, msg_schedule and the compression stage.
interface msg_schedule_if #(parameter int DATA_WIDTH = 32);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_in_valid;
    logic                  data_in_ready;
    logic [DATA_WIDTH-1:0] w_out;
    logic                  w_valid;
    logic [6:0]            w_round;
    logic                  sched_done;

    modport master (
        output data_in, data_in_valid,
        input  data_in_ready, w_out, w_valid, w_round, sched_done
    );
    modport slave (
        input  data_in, data_in_valid,
        output data_in_ready, w_out, w_valid, w_round, sched_done
    );
endinterface

// File: rtl/msg_schedule.sv
// SHA-256 message schedule: loads 16 words, then streams W0..W63 one per cycle
// from a 16-word sliding window.
module msg_schedule #(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    msg_schedule_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

    state_t                      r_state;
    logic [15:0][DATA_WIDTH-1:0] r_win;
    logic [3:0]                  r_load_cnt;
    logic [5:0]                  r_round_cnt;
    logic [DATA_WIDTH-1:0]       r_w_out;
    logic                        r_w_valid;
    logic [6:0]                  r_w_round;
    logic                        r_done;

    logic                        w_ready;
    logic                        w_xfer;
    logic [DATA_WIDTH-1:0]       w_next;

    function automatic logic [DATA_WIDTH-1:0] f_sig0(input logic [DATA_WIDTH-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] f_sig1(input logic [DATA_WIDTH-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Ready is gated by rst so nothing can be accepted while reset is held.
    assign w_ready = !rst && (r_state == S_IDLE || r_state == S_LOAD);
    assign w_xfer  = w_ready && bus.data_in_valid;
    // win[0] is W(t); the new entry becomes W(t+16).
    assign w_next  = f_sig1(r_win[14]) + r_win[9] + f_sig0(r_win[1]) + r_win[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_win       <= '0;
            r_load_cnt  <= '0;
            r_round_cnt <= '0;
            r_w_out     <= '0;
            r_w_valid   <= 1'b0;
            r_w_round   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_win      <= {bus.data_in, r_win[15:1]};
                        r_load_cnt <= 4'd1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_win      <= {bus.data_in, r_win[15:1]};
                        r_load_cnt <= r_load_cnt + 4'd1;
                        // Outputs are registered, so present the post-shift oldest word (win[1]).
                        if (r_load_cnt == 4'd15) begin
                            r_state     <= S_EXPAND;
                            r_round_cnt <= '0;
                            r_w_valid   <= 1'b1;
                            r_w_out     <= r_win[1];
                            r_w_round   <= '0;
                        end
                    end
                end
                S_EXPAND: begin
                    r_win       <= {w_next, r_win[15:1]};
                    r_round_cnt <= r_round_cnt + 6'd1;
                    if (r_round_cnt == 6'd63) begin
                        r_state   <= S_DONE;
                        r_w_valid <= 1'b0;
                        r_w_out   <= '0;
                        r_w_round <= '0;
                        r_done    <= 1'b1;
                    end else begin
                        r_w_out   <= r_win[1];
                        r_w_round <= {1'b0, r_round_cnt} + 7'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_in_ready = w_ready;
    assign bus.w_out         = r_w_out;
    assign bus.w_valid       = r_w_valid;
    assign bus.w_round       = r_w_round;
    assign bus.sched_done    = r_done;
endmodule

// File: doc/msg_schedule.md
# msg_schedule

Message schedule stage for the SHA-256 core, directly upstream of the compression stage. Accepts one 512-bit padded block as sixteen 32-bit big-endian words over a valid/ready handshake. Emits the 64 schedule words W0..W63 on 64 consecutive cycles, each tagged with its round index, for the compression stage to consume one word per cycle. Holds only a 16-word sliding window, not all 64 words.

## Interface
- DATA_WIDTH, 32, word width; only 32 is supported.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- data_in  in  DATA_WIDTH  message word M0..M15, first word first.
- data_in_valid  in  1  data_in is valid this cycle.
- data_in_ready  out  1  block accepts data_in this cycle; transfer occurs when valid && ready.
- w_out  out  DATA_WIDTH  schedule word Wt; 0 when w_valid=0.
- w_valid  out  1  w_out/w_round are valid.
- w_round  out  7  round index t (0..63); 0 when w_valid=0.
- sched_done  out  1  one-cycle pulse the cycle after W63 is presented.

## Operation
- Window: 16-entry register array win[0..15]; win[0] is the oldest word.
- States and transitions:
  - IDLE: data_in_ready=1. On transfer, write win[15], shift the window down, set load_cnt=1, go to LOAD.
  - LOAD: data_in_ready=1. Each transfer shifts data_in into win[15] and increments load_cnt. The transfer at load_cnt=15 (the 16th word) goes to EXPAND with round_cnt=0. Cycles without valid hold state.
  - EXPAND: data_in_ready=0, w_valid=1, w_out=win[0], w_round=round_cnt. Every cycle:
    - Shift window down.
    - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
    - round_cnt increments. At round_cnt=63, go to DONE.
  - DONE: sched_done=1, w_valid=0, data_in_ready=0. Next cycle go to IDLE.
- Word functions:
  - σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
  - All additions are 32-bit with carry-out discarded.
- Result: W0..W15 equal M0..M15 unchanged; W16..W63 follow FIPS 180-4.
- No back-pressure on the output; the downstream stage must take one word per cycle while w_valid=1.
- data_in_valid during EXPAND/DONE is ignored; no word is consumed.
- Window contents are not cleared between blocks; all 16 entries are overwritten by the next load.

## Timing
- Reset: state=IDLE; load_cnt=0, round_cnt=0; window cleared to 0.
  - While rst=1: w_out=0, w_valid=0, w_round=0, sched_done=0, data_in_ready=0.
  - First cycle after rst deasserts: data_in_ready=1.
- Load: minimum 16 cycles when valid is held high. Gaps in valid stretch the load with no other effect.
- Latency: w_valid rises in the cycle after the 16th transfer, presenting W0.
  - W63 is presented 63 cycles later.
  - sched_done is asserted the cycle after W63.
  - data_in_ready returns the cycle after that.
- Block-to-block spacing: 16 + 64 + 1 cycles minimum (81).
- rst asserted mid-LOAD or mid-EXPAND: the next edge forces the reset state. The partial block is discarded; no sched_done is produced.
- w_round is registered with w_out; both change only on clock edges.

## Test plan
- Reset check: assert rst for 3 cycles during EXPAND.
  - Next cycle: w_valid=0, w_round=0, w_out=0, sched_done=0.
  - After release: data_in_ready=1.
- "abc" block: M0=61626380, M1..M14=0, M15=00000018, valid held high.
  - W0..W15 echo the inputs.
  - W16=61626380, W17=000f0000, W18=7da86405.
  - All 64 words match the FIPS 180-4 software model; w_round runs 0..63 contiguously.
- Gapped load: same block with valid deasserted on every other cycle.
  - Identical W sequence.
  - w_valid rises exactly one cycle after the 16th transfer.
- Back-to-back blocks: the "abc" block, then a block of all ones (M0..M15=ffffffff) sent as soon as data_in_ready rises.
  - Second sequence matches the model.
  - No window contamination from the first block.
  - 81-cycle spacing between the two W0 presentations.
- Ignored input: data_in_valid=1 with garbage data throughout EXPAND.
  - Schedule unchanged.
  - No transfer occurs while data_in_ready=0.
  - sched_done pulses once.
- Mid-load reset: rst after 7 words, then a full "abc" load.
  - Output equals the clean "abc" sequence.
